// File: rtl/count_ones_pkg.sv
// Shared types and helpers for the count_ones_seq popcount sequencer.
// Holds the FSM state encoding and the count-width helper used by the top and chunk counter.
package count_ones_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bits needed to represent any count from 0 to n inclusive.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/count_ones_chunk.sv
// Combinational popcount of one CW-bit chunk.
// Built as a ripple chain of single-bit adds so it stays small for narrow chunks.
module count_ones_chunk
    import count_ones_pkg::*;
#(
    parameter  int CW  = 8,
    localparam int CCW = cnt_width(CW)
) (
    input  logic [CW-1:0]  chunk_i,
    output logic [CCW-1:0] count_o
);

    logic [CCW-1:0] sum [CW+1];

    assign sum[0] = '0;

    for (genvar gi = 0; gi < CW; gi++) begin : g_bit
        assign sum[gi+1] = sum[gi] + CCW'(chunk_i[gi]);
    end

    assign count_o = sum[CW];

endmodule

// File: rtl/count_ones_seq.sv
// Multi-cycle popcount sequencer: one CW-bit chunk per cycle through a shared counter.
// Optional macro COUNT_ONES_EARLY_EXIT_EN ends RUN as soon as the unprocessed remainder is zero.
module count_ones_seq
    import count_ones_pkg::*;
#(
    parameter  int DW = 32,
    parameter  int CW = 8,
    localparam int OW = cnt_width(DW)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [DW-1:0] in_data_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [OW-1:0] out_count_o,
    output logic          busy_o
);

    localparam int NCHUNK = DW / CW;
    localparam int CCW    = cnt_width(CW);
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    state_t         state_q,  state_d;
    logic [DW-1:0]  shreg_q,  shreg_d;
    logic [OW-1:0]  acc_q,    acc_d;
    logic [IW-1:0]  idx_q,    idx_d;
    logic [OW-1:0]  count_q,  count_d;

    logic [CCW-1:0] chunk_cnt;
    logic [OW-1:0]  acc_sum;
    logic           last_chunk;

    count_ones_chunk #(
        .CW      (CW)
    ) u_chunk (
        .chunk_i (shreg_q[CW-1:0]),
        .count_o (chunk_cnt)
    );

    assign acc_sum = acc_q + OW'(chunk_cnt);

`ifdef COUNT_ONES_EARLY_EXIT_EN
    // Nothing left above the current chunk means no further ones can be found.
    assign last_chunk = (idx_q == IW'(NCHUNK - 1)) || ((shreg_q >> CW) == '0);
`else
    assign last_chunk = (idx_q == IW'(NCHUNK - 1));
`endif

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    shreg_d = in_data_i;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d   = acc_sum;
                shreg_d = shreg_q >> CW;
                idx_d   = idx_q + IW'(1);
                if (last_chunk) begin
                    count_d = acc_sum;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            shreg_q <= '0;
            acc_q   <= '0;
            idx_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            count_q <= count_d;
        end
    end

    // Handshake flags decode registered state only, so no input-to-output paths exist.
    assign in_ready_o  = (state_q == IDLE);
    assign out_valid_o = (state_q == DONE);
    assign busy_o      = (state_q != IDLE);
    assign out_count_o = count_q;

endmodule
